// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and drives the IF/ID pipeline register.
// Fetch stops on a halt opcode and resumes only after a redirect or a reset.
module fetch_unit #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [3:0] HALT_OPCODE = 4'h4
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  imem_addr,
   input  logic [15:0] imem_instr,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   output logic [15:0] ifid_instr,
   output logic [7:0]  ifid_pc,
   output logic [7:0]  ifid_pc_plus1,
   output logic        ifid_valid,
   output logic        halted
);

   localparam int unsigned AW = 8;

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic          is_halt_op;

   assign imem_addr  = pc;
   assign is_halt_op = (imem_instr[15:12] == HALT_OPCODE);

   // Priority per edge: reset, redirect, halt hold, flush, stall, normal fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         pc            <= RESET_PC;
         ifid_instr    <= 16'h0000;
         ifid_pc       <= 8'h00;
         ifid_pc_plus1 <= 8'h00;
         ifid_valid    <= 1'b0;
         halted        <= 1'b0;
      end else if (redirect_valid) begin
         state      <= RUN;
         halted     <= 1'b0;
         pc         <= redirect_pc;
         ifid_valid <= 1'b0;
      end else if (state == HALT) begin
         ifid_valid <= 1'b0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_instr    <= imem_instr;
         ifid_pc       <= pc;
         ifid_pc_plus1 <= AW'(pc + AW'(1));
         ifid_valid    <= 1'b1;
         // The halt instruction itself is delivered; the PC parks on it.
         if (is_halt_op) begin
            state  <= HALT;
            halted <= 1'b1;
         end else begin
            pc <= AW'(pc + AW'(1));
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 Parameter HALT_OPCODE, default 4'h4, value of instr[15:12] that halts fetch.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-006 imem_addr  output  8  fetch address to instruction memory.
REQ-007 imem_instr  input  16  instruction returned combinationally for imem_addr in the same cycle.
REQ-008 stall  input  1  hold PC and IF/ID register.
REQ-009 flush  input  1  invalidate the IF/ID register.
REQ-010 redirect_valid  input  1  load PC from redirect_pc (branch/jump).
REQ-011 redirect_pc  input  8  redirect target address.
REQ-012 ifid_instr  output  16  registered instruction.
REQ-013 ifid_pc  output  8  registered address of ifid_instr.
REQ-014 ifid_pc_plus1  output  8  registered ifid_pc+1, mod 256.
REQ-015 ifid_valid  output  1  IF/ID contents are a real instruction, not a bubble.
REQ-016 halted  output  1  fetch is in HALT state.

Function
REQ-017 imem_addr SHALL equal the internal PC register combinationally; no other logic on the path.
REQ-018 State machine: RUN, HALT; per-edge priority: reset > redirect_valid > flush > stall > normal fetch.
REQ-019 Normal fetch (RUN, no redirect/flush/stall): ifid_instr<=imem_instr, ifid_pc<=PC, ifid_pc_plus1<=PC+1, ifid_valid<=1, PC<=PC+1.
REQ-020 Latency: instruction at address A SHALL appear on ifid_* at the edge after the cycle in which PC==A and no stall.
REQ-021 PC arithmetic SHALL be 8-bit modulo: 8'hFF+1 = 8'h00, no flag, no stop.
REQ-022 stall alone: PC and all ifid_* outputs SHALL hold their values, including ifid_valid.
REQ-023 flush (no redirect): ifid_valid<=0, PC holds, other ifid_* hold; flush wins over stall.
REQ-024 redirect_valid: PC<=redirect_pc, ifid_valid<=0, state<=RUN; overrides stall, flush and HALT.
REQ-025 HALT entry: on a normal fetch where imem_instr[15:12]==HALT_OPCODE, the halt instruction SHALL be latched with ifid_valid=1, PC SHALL NOT increment, state<=HALT.
REQ-026 In HALT: PC holds, ifid_valid<=0 every edge, other ifid_* hold, halted=1; stall and flush have no further effect.
REQ-027 HALT exits only via reset or redirect_valid; halted SHALL deassert on the same edge.
REQ-028 Halt opcode detection SHALL be ignored in cycles where stall, flush or redirect_valid is asserted.
REQ-029 halted SHALL be a registered output equal to (state==HALT).

Reset
REQ-030 On reset: PC<=RESET_PC, state<=RUN, ifid_instr<=16'h0000, ifid_pc<=8'h00, ifid_pc_plus1<=8'h00, ifid_valid<=0, halted<=0.
REQ-031 Reset SHALL override stall, flush, redirect_valid and HALT in the same cycle, including mid-operation.
REQ-032 During the reset cycle imem_addr SHALL show the pre-reset PC; it SHALL equal RESET_PC from the following cycle.

Verification
REQ-033 Memory 0:1125,1:114A,2:0632; release reset -> ifid_instr 1125/114A/0632, ifid_pc 00/01/02, ifid_valid 1 on edges 1-3.
REQ-034 stall high 2 cycles while PC=03 -> imem_addr stays 03, ifid_instr/pc/valid unchanged; resume -> mem[3] with ifid_pc 03.
REQ-035 redirect_valid with redirect_pc=07, stall=1, flush=1 simultaneously -> next edge ifid_valid 0, imem_addr 07; following edge ifid_pc 07, valid 1.
REQ-036 mem[8]=16'h4000 -> ifid_instr 4000 valid 1 once, then ifid_valid 0, halted 1, imem_addr 08 for 10 cycles; redirect_pc=00 -> halted 0, fetch resumes at 00.
REQ-037 redirect_pc=FF then run -> ifid_pc FF, ifid_pc_plus1 00; next imem_addr 00, no stop.
REQ-038 reset asserted during stall and during HALT -> all outputs at REQ-030 values after that edge, imem_addr = RESET_PC next cycle.
